// File: rtl/servo_cmd_parser.sv
// servo_cmd_parser: decodes 0xFF-headed X/Y position frames from a UART byte stream into clamped servo positions.
// Define SERVO_CMD_CHECKSUM_EN for 6-byte frames with a trailing mod-256 checksum byte.
module servo_cmd_parser #(
    parameter int unsigned MAX_POS        = 221,
    parameter int unsigned CENTER_POS     = 110,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       rx_err,
    output logic [9:0] pos_x,
    output logic [9:0] pos_y,
    output logic       update,
    output logic       frame_err
);
`ifdef SERVO_CMD_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_XH, S_XL, S_YH, S_YL, S_CK} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_XH, S_XL, S_YH, S_YL} state_t;
`endif
    localparam logic [9:0]  MAX_P   = 10'(MAX_POS);
    localparam logic [9:0]  CTR_P   = 10'(CENTER_POS);
    localparam logic [19:0] TO_LAST = 20'(TIMEOUT_CYCLES - 1);
    state_t      r_state, w_next;
    logic [19:0] r_cnt;
    logic [1:0]  r_xh, r_yh;
    logic [7:0]  r_xl;
    logic        w_done, w_discard;
    logic        w_hi_bad;
    logic [9:0]  w_y;
`ifdef SERVO_CMD_CHECKSUM_EN
    logic [7:0]  r_yl, r_sum;
    assign w_y = {r_yh, r_yl};
`else
    assign w_y = {r_yh, rx_data};
`endif
    assign w_hi_bad = |rx_data[7:2];

    function automatic logic [9:0] clamp(input logic [9:0] v);
        return (v > MAX_P) ? MAX_P : v;
    endfunction

    always_comb begin
        w_next    = r_state;
        w_done    = 1'b0;
        w_discard = 1'b0;
        if (r_state == S_IDLE) begin
            w_next = (rx_valid && rx_data == 8'hFF) ? S_XH : S_IDLE;
        end else if (rx_err) begin
            w_discard = 1'b1;
        end else if (rx_valid) begin
            case (r_state)
                S_XH: begin
                    w_next    = S_XL;
                    w_discard = w_hi_bad;
                end
                S_XL: w_next = S_YH;
                S_YH: begin
                    w_next    = S_YL;
                    w_discard = w_hi_bad;
                end
`ifdef SERVO_CMD_CHECKSUM_EN
                S_YL: w_next = S_CK;
                S_CK: begin
                    w_done    = (rx_data == r_sum);
                    w_discard = (rx_data != r_sum);
                end
`else
                S_YL: w_done = 1'b1;
`endif
                default: w_next = S_IDLE;
            endcase
        end else if (r_cnt == TO_LAST) begin
            w_discard = 1'b1;
        end
        if (w_discard || w_done) w_next = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_xh      <= '0;
            r_xl      <= '0;
            r_yh      <= '0;
`ifdef SERVO_CMD_CHECKSUM_EN
            r_yl      <= '0;
            r_sum     <= '0;
`endif
            pos_x     <= CTR_P;
            pos_y     <= CTR_P;
            update    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_cnt     <= (w_next == S_IDLE || rx_valid) ? 20'd0 : r_cnt + 20'd1;
            update    <= w_done;
            frame_err <= w_discard;
            if (rx_valid) begin
                if (r_state == S_XH) r_xh <= rx_data[1:0];
                if (r_state == S_XL) r_xl <= rx_data;
                if (r_state == S_YH) r_yh <= rx_data[1:0];
`ifdef SERVO_CMD_CHECKSUM_EN
                if (r_state == S_YL) r_yl <= rx_data;
                r_sum <= (r_state == S_IDLE) ? 8'd0 : r_sum + rx_data;
`endif
            end
            if (w_done) begin
                pos_x <= clamp({r_xh, r_xl});
                pos_y <= clamp(w_y);
            end
        end
    end
endmodule

// File: doc/servo_cmd_parser.md
# servo_cmd_parser

Receives the byte stream from the UART receiver, decodes fixed-length position frames for the two plate-tilt servos (X and Y), and drives the 10-bit `position` inputs of the two servo PWM drivers. Holds the last valid positions indefinitely. Rejects malformed or stalled frames without disturbing the outputs. Out-of-range commands are clamped so that the downstream 360-tick PWM frame is never overrun.

## Interface
- `MAX_POS`, 221: largest position passed downstream; larger commands are clamped to it.
- `CENTER_POS`, 110: position driven on both outputs after reset.
- `TIMEOUT_CYCLES`, 50000: allowed idle gap between bytes inside a frame, in clk cycles. Must be ≥2 and <2^20.
- `clk` input 1: system clock; all logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `rx_data` input 8: received byte.
- `rx_valid` input 1: one-cycle strobe; `rx_data` is valid in this cycle.
- `rx_err` input 1: one-cycle strobe; the UART detected a framing error.
- `pos_x` output 10: registered X position to the X PWM driver.
- `pos_y` output 10: registered Y position to the Y PWM driver.
- `update` output 1: one-cycle pulse when `pos_x`/`pos_y` take new values.
- `frame_err` output 1: one-cycle pulse when a frame is discarded.

## Operation
- Frame format: `0xFF` header, X_HI, X_LO, Y_HI, Y_LO, then CHK (CHK only when checksum is enabled).
  - Position = {HI[1:0], LO[7:0]}.
  - HI[7:2] must be zero.
- States: IDLE → XH → XL → YH → YL → (CK) → IDLE.
  - Each state advances on `rx_valid`.
  - In IDLE, any byte other than `0xFF` is ignored silently; no `frame_err`.
- Header recognition happens only in IDLE. A `0xFF` in a data slot is treated as data.
- Data bytes are captured into shadow registers. `pos_x`/`pos_y` change only on successful completion of a frame.
- Clamp rule: a position greater than `MAX_POS` is output as `MAX_POS`. Clamping is applied independently per axis.
- Discard conditions, each of which returns the FSM to IDLE, pulses `frame_err`, and leaves the outputs unchanged:
  - HI byte has nonzero bits [7:2]. Detected on that byte.
  - Checksum mismatch.
  - `rx_err` while not in IDLE.
  - Timeout.
- `rx_err` in IDLE: ignored.
- Timeout:
  - A cycle counter clears on every accepted byte and counts while not in IDLE.
  - Reaching `TIMEOUT_CYCLES` with no `rx_valid` in that cycle triggers a discard.
  - `rx_valid` in the same cycle takes priority over timeout.
- `rx_err` and `rx_valid` in the same cycle: `rx_err` wins. The byte is dropped and the frame is discarded.
- A new header arriving directly after a discard is accepted normally, because the FSM is already in IDLE.

## Timing
- Reset values:
  - `pos_x` = `pos_y` = `CENTER_POS`.
  - `update` = 0, `frame_err` = 0.
  - State = IDLE; timeout counter = 0.
- `rst` mid-frame: the partial frame is lost and outputs return to `CENTER_POS`. No `frame_err` is pulsed.
- Latency: on the clock edge that samples the final byte's `rx_valid`, `pos_x`, `pos_y` and `update` all register together. They are visible in the following cycle.
- `frame_err` asserts in the cycle after the offending byte, `rx_err`, or timeout cycle.
- `update` and `frame_err` are never high in the same cycle.
- Back-to-back bytes on consecutive cycles are fully supported; no backpressure exists.
- Positions are stable between `update` pulses, so the PWM driver may sample them on any cycle.

## Configuration
- `SERVO_CMD_CHECKSUM_EN` defined:
  - Frames are 6 bytes.
  - CHK = (X_HI + X_LO + Y_HI + Y_LO) mod 256.
  - A mismatch discards the frame.
- Not defined:
  - Frames are 5 bytes; the CK state is not built.
  - The frame completes on Y_LO.
  - All other checks (HI bits, `rx_err`, timeout) remain.

## Test plan
- Reset, then no stimulus → `pos_x` = `pos_y` = 110, `update` stays 0.
- Bytes FF 00 64 00 C8 2C (checksum enabled) → next cycle `pos_x` = 100, `pos_y` = 200, single `update` pulse.
- Bytes FF 03 FF 00 10 12 → `pos_x` = 221 (clamped from 1023), `pos_y` = 16, `update` pulse.
- Bytes FF 00 64 00 C8 2D (bad checksum) → `frame_err` pulse, positions unchanged, no `update`.
- Bytes FF 00 64, then a gap of 50000 cycles → `frame_err` pulse. A following valid frame is accepted.
- Bytes FF 04 …, or `rx_err` after FF 00 → `frame_err` pulse, FSM returns to IDLE. Stray bytes 12 34 in IDLE → no pulses.
